// File: rtl/netwalk_scan_encoder_if.sv
// ---------------------------------------------------------------------------
// netwalk_scan_encoder_if
// Handshake bundle between a request-bitmap producer / index consumer (master)
// and the netwalk scan encoder (slave).
//   in_valid / in_ready / in_vector   : request bitmap, producer -> encoder
//   out_valid / out_ready             : index beat handshake, encoder -> consumer
//   out_index / out_last / out_count  : current set-bit index, final flag, ordinal
//   out_zero                          : present only with NETWALK_SCAN_ENC_ZERO_FLAG_EN,
//                                       marks the single beat emitted for a zero vector
// ---------------------------------------------------------------------------
interface netwalk_scan_encoder_if #(
    parameter int OUT_W = 6,
    parameter int IN_W  = 1 << OUT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_vector;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_index;
    logic             out_last;
    logic [OUT_W-1:0] out_count;
`ifdef NETWALK_SCAN_ENC_ZERO_FLAG_EN
    logic             out_zero;

    modport master (
        output in_valid, in_vector, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_count, out_zero
    );

    modport slave (
        input  in_valid, in_vector, out_ready,
        output in_ready, out_valid, out_index, out_last, out_count, out_zero
    );
`else
    modport master (
        output in_valid, in_vector, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_count
    );

    modport slave (
        input  in_valid, in_vector, out_ready,
        output in_ready, out_valid, out_index, out_last, out_count
    );
`endif
endinterface

// File: rtl/netwalk_scan_encoder.sv
// ---------------------------------------------------------------------------
// netwalk_scan_encoder
// Sequential multi-hot encoder: accepts a request bitmap and emits the index of
// every set bit, one per accepted beat, lowest-first (LSB_FIRST=1) or
// highest-first (LSB_FIRST=0). Each beat carries out_last (final index of the
// vector) and out_count (0-based ordinal within the vector).
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : netwalk_scan_encoder_if.slave (in/out valid-ready handshakes)
// Optional feature macro: NETWALK_SCAN_ENC_ZERO_FLAG_EN
//   defined   -> a zero vector produces one out_zero beat (ZERO state)
//   undefined -> a zero vector is consumed and dropped
// ---------------------------------------------------------------------------
module netwalk_scan_encoder #(
    parameter int ENCODER_OUT_WIDTH = 6,
    parameter int ENCODER_IN_WIDTH  = 1 << ENCODER_OUT_WIDTH,
    parameter bit LSB_FIRST         = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    netwalk_scan_encoder_if.slave  bus
);

    localparam int OW = ENCODER_OUT_WIDTH;
    localparam int IW = ENCODER_IN_WIDTH;
    localparam logic [IW-1:0] ONE_VEC = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [OW-1:0] ONE_CNT = {{(OW-1){1'b0}}, 1'b1};

`ifdef NETWALK_SCAN_ENC_ZERO_FLAG_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_ZERO = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1
    } state_t;
`endif

    state_t          state_r;
    logic [IW-1:0]   pending_r;
    logic [OW-1:0]   count_r;
    logic            in_ready_r;
    logic            out_valid_r;
`ifdef NETWALK_SCAN_ENC_ZERO_FLAG_EN
    logic            zero_r;
`endif

    logic [OW-1:0]   sel_index_s;
    logic [IW-1:0]   sel_mask_s;
    logic            single_s;

    // Priority encode: the scan order decides which end wins.
    function automatic logic [OW-1:0] prio_encode(input logic [IW-1:0] vec);
        logic [OW-1:0] idx;
        idx = '0;
        if (LSB_FIRST) begin
            for (int i = IW - 1; i >= 0; i--) begin
                if (vec[i]) idx = OW'(i);
                else        idx = idx;
            end
        end else begin
            for (int i = 0; i < IW; i++) begin
                if (vec[i]) idx = OW'(i);
                else        idx = idx;
            end
        end
        return idx;
    endfunction

    // Current beat decode from the pending bitmap; x & (x-1) clears the lowest
    // set bit, so a zero result on a nonzero x means exactly one bit remains.
    always_comb begin
        sel_index_s = prio_encode(pending_r);
        sel_mask_s  = ONE_VEC << sel_index_s;
        single_s    = (pending_r != '0) && ((pending_r & (pending_r - ONE_VEC)) == '0);
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_index = sel_index_s;
    assign bus.out_count = count_r;
`ifdef NETWALK_SCAN_ENC_ZERO_FLAG_EN
    assign bus.out_last  = single_s | zero_r;
    assign bus.out_zero  = zero_r;
`else
    assign bus.out_last  = single_s;
`endif

    // Control FSM: accept a bitmap in IDLE, retire one bit per beat in SCAN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pending_r   <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef NETWALK_SCAN_ENC_ZERO_FLAG_EN
            zero_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_ready_r && bus.in_valid) begin
                        if (bus.in_vector != '0) begin
                            pending_r   <= bus.in_vector;
                            count_r     <= '0;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_SCAN;
                        end else begin
`ifdef NETWALK_SCAN_ENC_ZERO_FLAG_EN
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            zero_r      <= 1'b1;
                            state_r     <= ST_ZERO;
`else
                            // Zero vector is consumed and dropped.
                            in_ready_r  <= 1'b1;
`endif
                        end
                    end else begin
                        // Also raises in_ready on the first cycle after reset.
                        in_ready_r <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (bus.out_ready) begin
                        pending_r <= pending_r & ~sel_mask_s;
                        if (single_s) begin
                            count_r     <= '0;
                            out_valid_r <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            count_r <= count_r + ONE_CNT;
                        end
                    end else begin
                        pending_r <= pending_r;
                    end
                end
`ifdef NETWALK_SCAN_ENC_ZERO_FLAG_EN
                ST_ZERO: begin
                    if (bus.out_ready) begin
                        zero_r      <= 1'b0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        zero_r <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_r     <= ST_IDLE;
                    pending_r   <= '0;
                    count_r     <= '0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
`ifdef NETWALK_SCAN_ENC_ZERO_FLAG_EN
                    zero_r      <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule
